ram_wr_sched: RTL

//  Write-port scheduler for the dual-clock pixel/palette RAM (8-bit address, 12-bit data).

---
 rtl/ram_wr_sched_pkg.sv | 11 +
 rtl/ram_wr_sched_rr_arb2.sv | 49 ++++
 rtl/ram_wr_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ram_wr_sched_pkg.sv
// Shared types and helpers for the RAM write-port scheduler.
package ram_wr_sched_pkg;

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic {SEL_A, SEL_B} req_sel_t;

  function automatic int ram_depth(input int addr_width);
    return 32'sd1 <<< addr_width;
  endfunction

endpackage

// File: rtl/ram_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter; ptr names the requester that wins the next tie.
module rr_arb2
  import ram_wr_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output req_sel_t   ptr
);

  req_sel_t ptr_q;
  req_sel_t ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (accept) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr_q == SEL_A) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
    // The loser of a granted cycle gets priority on the next tie.
    if (gnt[0]) begin
      ptr_d = SEL_B;
    end else if (gnt[1]) begin
      ptr_d = SEL_A;
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= SEL_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_wr_sched.sv
// RAM write-port scheduler: round-robin A/B writes plus a full-RAM clear engine.
// Optional write statistics counter enabled by defining RAM_WR_SCHED_STATS_EN.
module ram_wr_sched
  import ram_wr_sched_pkg::*;
#(
  parameter int RAM_WIDTH  = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [RAM_WIDTH-1:0]  a_add,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [RAM_WIDTH-1:0]  b_add,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_value,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_req,
  output logic [RAM_WIDTH-1:0]  wr_add,
  output logic [DATA_WIDTH-1:0] wr_data
`ifdef RAM_WR_SCHED_STATS_EN
  ,
  output logic [15:0]           wr_count
`endif
);

  // Counter carries one extra bit so reaching DEPTH marks "all addresses issued".
  localparam logic [RAM_WIDTH:0] CLR_END = (RAM_WIDTH+1)'(ram_depth(RAM_WIDTH));
  localparam logic [RAM_WIDTH:0] CNT_ONE = {{RAM_WIDTH{1'b0}}, 1'b1};

  state_t                state_q;
  logic [RAM_WIDTH:0]    clr_cnt_q;
  logic [DATA_WIDTH-1:0] clr_val_q;
  logic                  wr_req_q;
  logic [RAM_WIDTH-1:0]  wr_add_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  clr_busy_q;
  logic                  clr_done_q;

  logic                  arb_accept_s;
  logic [1:0]            arb_gnt_s;
  req_sel_t              arb_ptr_s;
  req_sel_t              win_s;

  assign arb_accept_s = (state_q == IDLE) && !clr_start;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({b_valid, a_valid}),
    .accept (arb_accept_s),
    .gnt    (arb_gnt_s),
    .ptr    (arb_ptr_s)
  );

  assign a_ready = arb_gnt_s[0];
  assign b_ready = arb_gnt_s[1];
  assign win_s   = (a_valid && b_valid) ? arb_ptr_s : (a_valid ? SEL_A : SEL_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_val_q  <= '0;
      wr_req_q   <= 1'b0;
      wr_add_q   <= '0;
      wr_data_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            // Address 0 goes out immediately; the counter continues from 1.
            state_q    <= CLEAR;
            clr_busy_q <= 1'b1;
            clr_val_q  <= clr_value;
            clr_cnt_q  <= CNT_ONE;
            wr_req_q   <= 1'b1;
            wr_add_q   <= '0;
            wr_data_q  <= clr_value;
          end else if (|arb_gnt_s) begin
            wr_req_q  <= 1'b1;
            wr_add_q  <= (win_s == SEL_A) ? a_add : b_add;
            wr_data_q <= (win_s == SEL_A) ? a_data : b_data;
          end else begin
            wr_req_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == CLR_END) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
            wr_req_q   <= 1'b0;
          end else begin
            wr_req_q  <= 1'b1;
            wr_add_q  <= clr_cnt_q[RAM_WIDTH-1:0];
            wr_data_q <= clr_val_q;
            clr_cnt_q <= clr_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q    <= IDLE;
          clr_busy_q <= 1'b0;
          wr_req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wr_req   = wr_req_q;
  assign wr_add   = wr_add_q;
  assign wr_data  = wr_data_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

`ifdef RAM_WR_SCHED_STATS_EN
  logic [15:0] wr_count_q;
  logic [15:0] wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_req_q && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= 16'd0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule
